pp_fetch: RTL

Instruction fetch unit for the pulse programmer. It reads 64-bit words from the read side (port B) of the ppmem6 dual-port program memory, which the host fills 16 bits at a time through port A. It keeps a small prefetch FIFO of instructions, already read from memory, ready for the pulse-program core. It also handles start, stop and jump requests from that core.

---
 rtl/pp_fetch_pkg.sv | 17 +
 rtl/pp_fetch_if.sv | 31 +++
 rtl/pp_fetch_fifo.sv | 54 +++++
 rtl/pp_fetch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pp_fetch_pkg.sv
// Shared types and defaults for the pulse-programmer instruction fetch unit.
package pp_fetch_pkg;

    localparam int PP_ADDR_W = 12;
    localparam int PP_DATA_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [PP_ADDR_W-1:0] addr;
    } inflight_t;

endpackage

// File: rtl/pp_fetch_if.sv
// Control, memory read port and instruction stream of the fetch unit.
interface pp_fetch_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stop;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic              busy;

    // Environment side: core requests, memory data, consumer ready.
    modport master (
        output start, start_addr, stop, jump, jump_addr, mem_dout, instr_ready,
        input  mem_en, mem_addr, instr_data, instr_addr, instr_valid, busy
    );

    // Fetch unit side.
    modport slave (
        input  start, start_addr, stop, jump, jump_addr, mem_dout, instr_ready,
        output mem_en, mem_addr, instr_data, instr_addr, instr_valid, busy
    );
endinterface

// File: rtl/pp_fetch_fifo.sv
// Show-ahead prefetch FIFO holding {addr, data}; synchronous flush and occupancy count.
module pp_fetch_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_rd;

    assign w_do_rd   = i_rd_en && (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);

    // Writer never exceeds DEPTH: the fetch credit scheme bounds occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (PTR_W+1)'(i_wr_en) - (PTR_W+1)'(w_do_rd);
        end
    end

endmodule

// File: rtl/pp_fetch.sv
// Instruction fetch unit: reads program words from ppmem6 port B into a credit-limited prefetch FIFO.
//   state   | meaning
//   IDLE    | no reads issued, busy low
//   RUN     | issuing reads of pc while credit remains, busy high
module pp_fetch
    import pp_fetch_pkg::*;
#(
    parameter int ADDR_W     = PP_ADDR_W,
    parameter int DATA_W     = PP_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pp_fetch_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;
    localparam int FW    = ADDR_W + DATA_W;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("pp_fetch: RD_LAT must be in 1..3");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("pp_fetch: FIFO_DEPTH must be a power of 2 and at least RD_LAT+2");
    end
    if (ADDR_W != PP_ADDR_W) begin : g_bad_addr
        $error("pp_fetch: ADDR_W must match the in-flight entry address width");
    end

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_pc;
    logic [ADDR_W-1:0]        w_pc_next;
    logic                     r_mem_en;
    logic                     w_mem_en_next;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [ADDR_W-1:0]        w_mem_addr_next;
    inflight_t                r_sr [RD_LAT];
    logic                     w_stop_req;
    logic                     w_redirect;
    logic                     w_flush;
    logic                     w_pop;
    logic [ADDR_W-1:0]        w_target;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                     w_fifo_empty;
    logic [CNT_W-1:0]         w_outstanding;
    logic [FW-1:0]            w_head;

    // Request decode: stop beats jump beats start; start while running is a jump.
    always_comb begin
        w_stop_req = (r_state == ST_RUN) && bus.stop;
        w_redirect = !w_stop_req && (bus.start || ((r_state == ST_RUN) && bus.jump));
        w_target   = ((r_state == ST_RUN) && bus.jump) ? bus.jump_addr : bus.start_addr;
        w_flush    = w_stop_req || w_redirect;
        w_pop      = !w_fifo_empty && bus.instr_ready;
    end

    // Words committed to the FIFO: stored, returning from memory, or just issued.
    always_comb begin
        w_outstanding = CNT_W'(w_fifo_count) + CNT_W'(r_mem_en);
        for (int k = 0; k < RD_LAT; k++) begin
            w_outstanding = w_outstanding + CNT_W'(r_sr[k].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_stop_req) begin
            w_state_next = ST_IDLE;
        end else if (w_redirect) begin
            w_state_next = ST_RUN;
        end
    end

    // A pop on this edge frees a slot, which keeps one word per cycle flowing.
    always_comb begin
        w_mem_en_next   = 1'b0;
        w_mem_addr_next = r_mem_addr;
        w_pc_next       = r_pc;
        if (w_redirect) begin
            w_mem_en_next   = 1'b1;
            w_mem_addr_next = w_target;
            w_pc_next       = w_target + 1'b1;
        end else if ((r_state == ST_RUN) && !w_stop_req) begin
            if ((w_outstanding - CNT_W'(w_pop)) < CNT_W'(FIFO_DEPTH)) begin
                w_mem_en_next   = 1'b1;
                w_mem_addr_next = r_pc;
                w_pc_next       = r_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_sr[k] <= '0;
            end
        end else begin
            r_pc       <= w_pc_next;
            r_mem_en   <= w_mem_en_next;
            r_mem_addr <= w_mem_addr_next;
            r_sr[0]    <= w_flush ? '0 : inflight_t'{valid: r_mem_en, addr: r_mem_addr};
            for (int k = 1; k < RD_LAT; k++) begin
                r_sr[k] <= w_flush ? '0 : r_sr[k-1];
            end
        end
    end

    pp_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_flush   (w_flush),
        .i_wr_en   (r_sr[RD_LAT-1].valid),
        .i_wr_data ({r_sr[RD_LAT-1].addr, bus.mem_dout}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    assign bus.mem_en      = r_mem_en;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.instr_valid = !w_fifo_empty;
    assign bus.instr_addr  = w_head[FW-1:DATA_W];
    assign bus.instr_data  = w_head[DATA_W-1:0];

endmodule
